// File: rtl/vec_pkg.sv
// Shared types for the scalar-core offload endpoint: request/response payloads and ROB entries.
package vec_pkg;

  localparam int XLEN          = 32;
  localparam int TRANS_ID_BITS = 3;

  typedef logic [TRANS_ID_BITS-1:0] trans_id_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    trans_id_t       instr_id;
  } sca_req_t;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] res;
    trans_id_t       instr_id;
  } sca_resp_t;

  typedef struct packed {
    logic            valid;
    logic            done;
    trans_id_t       id;
    logic            err;
    logic [XLEN-1:0] res;
  } rob_entry_t;

endpackage

// File: rtl/vec_sca_rob.sv
// Reorder buffer: allocates at tail, retires at head, and matches ids for duplicate
// detection and out-of-order completion.
module vec_sca_rob
  import vec_pkg::*;
#(
  parameter int ROB_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            alloc_i,
  input  trans_id_t       alloc_id_i,
  input  trans_id_t       query_id_i,
  output logic            dup_o,
  output logic            full_o,
  input  logic            cpl_valid_i,
  input  trans_id_t       cpl_id_i,
  input  logic            cpl_err_i,
  input  logic [XLEN-1:0] cpl_res_i,
  output logic            unk_cpl_o,
  output rob_entry_t      head_o,
  input  logic            retire_i
);

  localparam int PW = $clog2(ROB_DEPTH);

  rob_entry_t             rob_q [ROB_DEPTH];
  logic [PW-1:0]          head_q, tail_q;
  logic [PW:0]            count_q;
  logic [ROB_DEPTH-1:0]   cpl_hit;

  // Ids are unique among valid entries, so at most one entry can hit.
  always_comb begin
    dup_o   = 1'b0;
    cpl_hit = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      if (rob_q[i].valid && (rob_q[i].id == query_id_i)) dup_o = 1'b1;
      cpl_hit[i] = cpl_valid_i && rob_q[i].valid && !rob_q[i].done &&
                   (rob_q[i].id == cpl_id_i);
    end
  end

  assign full_o = (count_q == (PW+1)'(ROB_DEPTH));
  assign head_o = rob_q[head_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ROB_DEPTH; i++) rob_q[i] <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      unk_cpl_o <= 1'b0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (cpl_hit[i]) begin
          rob_q[i].done <= 1'b1;
          rob_q[i].err  <= cpl_err_i;
          rob_q[i].res  <= cpl_res_i;
        end
      end
      if (alloc_i) begin
        rob_q[tail_q] <= '{valid: 1'b1, done: 1'b0, id: alloc_id_i, err: 1'b0, res: '0};
        tail_q        <= tail_q + 1'b1;
      end
      // Retire clears the whole entry, so a bypassed completion on the head never leaves done set.
      if (retire_i) begin
        rob_q[head_q] <= '0;
        head_q        <= head_q + 1'b1;
      end
      if (alloc_i && !retire_i)      count_q <= count_q + 1'b1;
      else if (!alloc_i && retire_i) count_q <= count_q - 1'b1;
      if (cpl_valid_i && (cpl_hit == '0)) unk_cpl_o <= 1'b1;
    end
  end

endmodule

// File: rtl/vec_sca_resp_ctrl.sv
// Offload endpoint: registers accepted requests toward the decoder and returns responses in order.
// Optional same-cycle completion-to-response bypass under VEC_SCA_CPL_BYPASS_EN.
module vec_sca_resp_ctrl
  import vec_pkg::*;
#(
  parameter int ROB_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  sca_req_t        req_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output sca_req_t        dec_req_o,
  input  logic            cpl_valid_i,
  input  trans_id_t       cpl_id_i,
  input  logic            cpl_err_i,
  input  logic [XLEN-1:0] cpl_res_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output sca_resp_t       resp_o,
  output logic            unk_cpl_o
);

  logic       full, dup, accept, retire;
  rob_entry_t head;

  assign req_ready_o = !full && (!dec_valid_o || dec_ready_i) && !dup;
  assign accept      = req_valid_i && req_ready_o;
  assign retire      = resp_valid_o && resp_ready_i;

  vec_sca_rob #(.ROB_DEPTH(ROB_DEPTH)) u_rob (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .alloc_i     (accept),
    .alloc_id_i  (req_i.instr_id),
    .query_id_i  (req_i.instr_id),
    .dup_o       (dup),
    .full_o      (full),
    .cpl_valid_i (cpl_valid_i),
    .cpl_id_i    (cpl_id_i),
    .cpl_err_i   (cpl_err_i),
    .cpl_res_i   (cpl_res_i),
    .unk_cpl_o   (unk_cpl_o),
    .head_o      (head),
    .retire_i    (retire)
  );

  // Decoder skid register: a new accept may overwrite on the same edge as the handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_valid_o <= 1'b0;
      dec_req_o   <= '0;
    end else if (accept) begin
      dec_valid_o <= 1'b1;
      dec_req_o   <= req_i;
    end else if (dec_ready_i) begin
      dec_valid_o <= 1'b0;
    end
  end

  always_comb begin
    resp_valid_o = head.valid && head.done;
    resp_o       = '{err: head.err, res: head.res, instr_id: head.id};
`ifdef VEC_SCA_CPL_BYPASS_EN
    if (cpl_valid_i && head.valid && !head.done && (head.id == cpl_id_i)) begin
      resp_valid_o = 1'b1;
      resp_o.err   = cpl_err_i;
      resp_o.res   = cpl_res_i;
    end
`endif
  end

endmodule
